// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI transfer sequencer.
// Handles slave-select setup/hold, bit counting and clock-generator control.
module spi_xfer_ctrl #(
  parameter int CS_DLY = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] char_len,
  input  logic       tx_negedge,
  input  logic       rx_negedge,
  input  logic       pos_edge,
  input  logic       neg_edge,
  output logic       go,
  output logic       enable,
  output logic       last_clk,
  output logic       ss_n,
  output logic       tx_shift,
  output logic       rx_sample,
  output logic [7:0] bit_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  localparam logic [3:0] DLY_LAST = 4'(CS_DLY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] dly;
  logic [7:0] bit_cnt_nxt;
  logic       go_d;
  logic       enable_d;
  logic       last_clk_d;
  logic       ss_n_d;
  logic       busy_d;
  logic       done_d;

  assign tx_shift  = enable & (tx_negedge ? neg_edge : pos_edge);
  assign rx_sample = enable & (rx_negedge ? neg_edge : pos_edge);

  // State, per-state cycle counter and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      dly      <= '0;
      bit_cnt  <= '0;
      go       <= 1'b0;
      enable   <= 1'b0;
      last_clk <= 1'b0;
      ss_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dly      <= (state_nxt != state) ? 4'd0 : dly + 4'd1;
      bit_cnt  <= bit_cnt_nxt;
      go       <= go_d;
      enable   <= enable_d;
      last_clk <= last_clk_d;
      ss_n     <= ss_n_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state and bit counter; abort overrides every transition
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt   = SETUP;
          bit_cnt_nxt = (char_len == 7'd0) ? 8'd128
                                           : {1'b0, char_len};
        end
      end
      SETUP: begin
        if (dly == DLY_LAST)
          state_nxt = XFER;
      end
      XFER: begin
        if (rx_sample && bit_cnt != 8'd0)
          bit_cnt_nxt = bit_cnt - 8'd1;
        if (neg_edge &&
            (bit_cnt == 8'd0 ||
             (bit_cnt == 8'd1 && rx_negedge)))
          state_nxt = HOLD;
      end
      HOLD: begin
        if (dly == DLY_LAST)
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    go_d       = (state == IDLE) && (state_nxt == SETUP);
    enable_d   = (state_nxt == XFER);
    last_clk_d = (state_nxt == XFER) && (bit_cnt_nxt <= 8'd1);
    busy_d     = (state_nxt == SETUP) ||
                 (state_nxt == XFER)  ||
                 (state_nxt == HOLD);
    ss_n_d     = !busy_d;
    done_d     = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench for spi_xfer_ctrl.
// Edge pulses come from a small clock-generator model driven by enable.
module tb_spi_xfer_ctrl;

  localparam int CS_DLY = 2;

  typedef struct {
    int load;
    int rx;
    int tx;
    int en;
    bit ab;
  } exp_t;

  logic       clk_in;
  logic       rst;
  logic       start;
  logic       abort;
  logic [6:0] char_len;
  logic       tx_negedge;
  logic       rx_negedge;
  logic       pos_edge;
  logic       neg_edge;
  logic       go;
  logic       enable;
  logic       last_clk;
  logic       ss_n;
  logic       tx_shift;
  logic       rx_sample;
  logic [7:0] bit_cnt;
  logic       busy;
  logic       done;

  int   checks = 0;
  int   errors = 0;
  int   gcnt   = 0;
  exp_t sb[$];

  spi_xfer_ctrl #(.CS_DLY(CS_DLY)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .char_len  (char_len),
    .tx_negedge(tx_negedge),
    .rx_negedge(rx_negedge),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .go        (go),
    .enable    (enable),
    .last_clk  (last_clk),
    .ss_n      (ss_n),
    .tx_shift  (tx_shift),
    .rx_sample (rx_sample),
    .bit_cnt   (bit_cnt),
    .busy      (busy),
    .done      (done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Clock generator model: first edge is a pos_edge, period 4 cycles
  always @(posedge clk_in) begin
    if (!enable) gcnt <= 0;
    else         gcnt <= gcnt + 1;
  end
  assign pos_edge = enable && (gcnt % 4 == 1);
  assign neg_edge = enable && (gcnt % 4 == 3);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_go"},       go,       0);
    chk({nm, "_enable"},   enable,   0);
    chk({nm, "_last_clk"}, last_clk, 0);
    chk({nm, "_ss_n"},     ss_n,     1);
    chk({nm, "_bit_cnt"},  bit_cnt,  0);
    chk({nm, "_busy"},     busy,     0);
    chk({nm, "_done"},     done,     0);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic go_xfer(input logic [6:0] len,
                         input logic rxn, input logic txn);
    tick();
    char_len   = len;
    rx_negedge = rxn;
    tx_negedge = txn;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_en(input int lim);
    int n = 0;
    while (!enable && n < lim) begin tick(); n++; end
    chk("wait_en_timeout", int'(n < lim), 1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (!busy && n < lim) begin tick(); n++; end
    while (busy && n < lim) begin tick(); n++; end
    chk("wait_idle_timeout", int'(n < lim), 1);
  endtask

  // Monitor: measures each transfer and checks it against the scoreboard
  initial begin : monitor
    int  m_rx, m_tx, m_en, m_su, m_ho;
    bit  seen, prev_busy, prev_done;
    exp_t e;
    m_rx = 0; m_tx = 0; m_en = 0; m_su = 0; m_ho = 0;
    seen = 0; prev_busy = 0; prev_done = 0;
    forever begin
      @(negedge clk_in);
      if (busy) begin
        chk("go_once", go, int'(!prev_busy));
        if (!prev_busy) begin
          m_rx = 0; m_tx = 0; m_en = 0; m_su = 0; m_ho = 0;
          seen = 0;
          if (sb.size() > 0) chk("bit_cnt_load", bit_cnt, sb[0].load);
        end
        m_rx += int'(rx_sample);
        m_tx += int'(tx_shift);
        if (enable) begin
          m_en++;
          seen = 1;
        end else if (!seen) m_su++;
        else m_ho++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got transfer end, expected none");
        end else begin
          e = sb.pop_front();
          chk("done_flag", done, int'(!e.ab));
          chk("rx_count", m_rx, e.rx);
          chk("tx_count", m_tx, e.tx);
          if (!e.ab) begin
            chk("xfer_cycles", m_en, e.en);
            chk("setup_cycles", m_su, CS_DLY);
            chk("hold_cycles", m_ho, CS_DLY);
          end
        end
      end
      if (prev_done) chk("done_one_cycle", done, 0);
      prev_busy = busy;
      prev_done = done;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    char_len   = 7'd0;
    tx_negedge = 1'b0;
    rx_negedge = 1'b0;
    repeat (3) tick();
    chk_reset("por");
    rst = 1'b0;
    tick();

    // 8 bits, sample on pos, drive on neg
    sb.push_back('{load: 8, rx: 8, tx: 8, en: 32, ab: 0});
    go_xfer(7'd8, 1'b0, 1'b1);
    wait_idle(500);

    // char_len 0 means 128 bits
    sb.push_back('{load: 128, rx: 128, tx: 128, en: 512, ab: 0});
    go_xfer(7'd0, 1'b0, 1'b0);
    wait_idle(2000);

    // single bit sampled on neg_edge
    sb.push_back('{load: 1, rx: 1, tx: 1, en: 4, ab: 0});
    go_xfer(7'd1, 1'b1, 1'b0);
    wait_en(20);
    chk("last_clk_first", last_clk, 1);
    wait_idle(100);

    // abort at bit_cnt 5
    sb.push_back('{load: 8, rx: 3, tx: 2, en: 0, ab: 1});
    go_xfer(7'd8, 1'b0, 1'b1);
    n = 0;
    while (!(enable && bit_cnt == 8'd5) && n < 100) begin tick(); n++; end
    chk("wait_cnt5_timeout", int'(n < 100), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ss_n", ss_n, 1);
    chk("abort_enable", enable, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bit_cnt", bit_cnt, 0);
    chk("abort_done", done, 0);
    repeat (4) tick();

    // reset in HOLD, then a normal transfer
    sb.push_back('{load: 4, rx: 4, tx: 4, en: 0, ab: 1});
    go_xfer(7'd4, 1'b0, 1'b1);
    wait_en(20);
    n = 0;
    while (enable && n < 100) begin tick(); n++; end
    chk("wait_hold_timeout", int'(n < 100), 1);
    chk("in_hold_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk_reset("rst_hold");
    rst = 1'b0;
    sb.push_back('{load: 3, rx: 3, tx: 3, en: 12, ab: 0});
    go_xfer(7'd3, 1'b0, 1'b1);
    wait_idle(200);

    // start held: second transfer only after DONE then IDLE
    sb.push_back('{load: 2, rx: 2, tx: 2, en: 8, ab: 0});
    sb.push_back('{load: 2, rx: 2, tx: 2, en: 8, ab: 0});
    tick();
    char_len   = 7'd2;
    rx_negedge = 1'b0;
    tx_negedge = 1'b0;
    start      = 1'b1;
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("wait_done_timeout", int'(n < 200), 1);
    tick();
    chk("gap_ss_n", ss_n, 1);
    chk("gap_busy", busy, 0);
    chk("gap_go", go, 0);
    tick();
    chk("restart_go", go, 1);
    chk("restart_ss_n", ss_n, 0);
    start = 1'b0;
    wait_idle(200);

    // abort with start in IDLE stays idle
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_go", go, 0);
    chk("idle_abort_ss_n", ss_n, 1);

    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter CS_DLY, default 2: SS setup and hold time in clk_in cycles, legal range 1..15.
REQ-002 SHALL have port clk_in, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1: transfer request; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1: cancel any transfer in progress.
REQ-006 SHALL have port char_len, input, 7: bits per transfer; 0 encodes 128.
REQ-007 SHALL have port tx_negedge, input, 1: 1 = drive MOSI on neg_edge, 0 = drive on pos_edge.
REQ-008 SHALL have port rx_negedge, input, 1: 1 = sample MISO on neg_edge, 0 = sample on pos_edge.
REQ-009 SHALL have ports pos_edge and neg_edge, inputs, 1 each: edge pulses from the clock generator.
REQ-010 SHALL have port go, output, 1: one-cycle start pulse to the clock generator.
REQ-011 SHALL have port enable, output, 1: clock-generator enable.
REQ-012 SHALL have port last_clk, output, 1: final-bit indication to the clock generator.
REQ-013 SHALL have port ss_n, output, 1: slave select, active-low.
REQ-014 SHALL have ports tx_shift and rx_sample, outputs, 1 each: shift-register strobes.
REQ-015 SHALL have port bit_cnt, output, 8: bits remaining.
REQ-016 SHALL have ports busy, output, 1, and done, output, 1: transfer active and one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, XFER, HOLD, DONE; all outputs registered except tx_shift and rx_sample.
REQ-018 IDLE SHALL drive enable=0, ss_n=1, busy=0, go=0, last_clk=0.
REQ-019 start=1 in IDLE SHALL, next cycle: state=SETUP; bit_cnt=char_len zero-extended, or 128 when char_len=0; go=1 for exactly that cycle.
REQ-020 SETUP SHALL hold ss_n=0, busy=1, enable=0 for exactly CS_DLY cycles, then enter XFER with enable=1.
REQ-021 tx_shift SHALL equal enable AND (tx_negedge ? neg_edge : pos_edge); rx_sample SHALL equal enable AND (rx_negedge ? neg_edge : pos_edge).
REQ-022 Each rx_sample in XFER SHALL decrement bit_cnt by 1; bit_cnt SHALL never wrap below 0.
REQ-023 last_clk SHALL be 1 in XFER while bit_cnt<=1, else 0.
REQ-024 XFER SHALL exit to HOLD on the first neg_edge when bit_cnt==0, or when bit_cnt==1 and rx_negedge=1 (same-cycle decrement); enable SHALL drop to 0 the next cycle.
REQ-025 HOLD SHALL keep ss_n=0, enable=0 for CS_DLY cycles, then enter DONE.
REQ-026 DONE SHALL last one cycle with done=1, ss_n=1, busy=0, then return to IDLE.
REQ-027 start outside IDLE SHALL be ignored; start=1 in the DONE cycle SHALL NOT be accepted until IDLE.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE next cycle: enable=0, ss_n=1, done=0, bit_cnt=0; abort has priority over every other transition.
REQ-029 abort and start together in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-030 rst=1 at a clock edge SHALL set state=IDLE, go=0, enable=0, last_clk=0, ss_n=1, bit_cnt=0, busy=0, done=0, regardless of state, including mid-XFER.
REQ-031 rst SHALL take priority over abort and start.

Verification
REQ-032 char_len=8, CS_DLY=2, rx_negedge=0, tx_negedge=1, edges every 4 cycles -> go pulses 1 cycle; 8 rx_sample, 8 tx_shift; ss_n low 2 cycles before enable; done 1 cycle after 2-cycle hold.
REQ-033 char_len=0 -> bit_cnt loads 128; exactly 128 rx_sample pulses, then done.
REQ-034 char_len=1, rx_negedge=1 -> last_clk=1 from first XFER cycle; XFER exits on the single sampling neg_edge.
REQ-035 abort asserted mid-XFER at bit_cnt=5 -> next cycle IDLE, ss_n=1, enable=0, no done pulse.
REQ-036 rst asserted in HOLD -> all outputs at reset values next cycle; following start runs a normal transfer.
REQ-037 start held high through a whole transfer -> a second transfer begins only after DONE-to-IDLE, with one idle cycle at ss_n=1 between transfers.
